// File: rtl/msp_icb_streamer.sv
// ICB master that streams packed PCM words into the mel-spectrogram slave
// and drains the per-hop mel result words to a downstream stream.
// One ICB transaction is outstanding at a time; error responses park the
// block in ERR with a sticky fault until clr_err.
module msp_icb_streamer #(
  parameter logic [31:0] WR_ADDR  = 32'h1004_2000,
  parameter logic [31:0] RD_ADDR  = 32'h1004_2004,
  parameter int unsigned WR_WORDS = 80,
  parameter int unsigned RD_WORDS = 10,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr_err,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic [31:0] icb_cmd_addr,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_wdata,
  output logic [3:0]  icb_cmd_wmask,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata,
  input  logic        icb_rsp_err,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_code,
  output logic [15:0] hop_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WR_CMD, WR_RSP, RD_CMD, RD_RSP, ERR
  } state_t;

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WORDS - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [31:0]      wdata;
  logic             wr_last, rd_last;
  logic             wr_rsp_hs, rd_rsp_hs;

  assign wr_last       = (wr_cnt == WR_LAST);
  assign rd_last       = (rd_cnt == RD_LAST);
  assign icb_cmd_wdata = wdata;
  assign icb_cmd_wmask = 4'hF;
  assign wr_rsp_hs     = (state == WR_RSP) && icb_rsp_valid;
  assign rd_rsp_hs     = (state == RD_RSP) && icb_rsp_valid && icb_rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs, all decoded from the current state
  always_comb begin
    state_nxt     = state;
    s_ready       = 1'b0;
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = '0;
    icb_rsp_ready = 1'b0;
    busy          = (state != IDLE) && (state != ERR);
    unique case (state)
      IDLE: if (en) state_nxt = FETCH;
      FETCH: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = WR_CMD;
      end
      WR_CMD: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = WR_ADDR;
        if (icb_cmd_ready) state_nxt = WR_RSP;
      end
      WR_RSP: begin
        icb_rsp_ready = 1'b1;
        if (icb_rsp_valid) begin
          if (icb_rsp_err)  state_nxt = ERR;
          else if (wr_last) state_nxt = RD_CMD;
          else              state_nxt = FETCH;
        end
      end
      RD_CMD: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = RD_ADDR;
        if (icb_cmd_ready) state_nxt = RD_RSP;
      end
      RD_RSP: begin
        // Only accept a result when the output register can take it.
        icb_rsp_ready = !m_valid || m_ready;
        if (icb_rsp_valid && icb_rsp_ready) begin
          if (icb_rsp_err)  state_nxt = ERR;
          else if (!rd_last) state_nxt = RD_CMD;
          else if (en)      state_nxt = FETCH;
          else              state_nxt = IDLE;
        end
      end
      ERR: if (clr_err) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write data latched on the upstream handshake, held through WR_CMD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wdata <= '0;
    else if (s_ready && s_valid) wdata <= s_data;
  end

  // Beat counters and completed-hop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      hop_cnt <= '0;
    end else begin
      if (wr_rsp_hs && !icb_rsp_err) begin
        if (wr_last) wr_cnt <= '0;
        else         wr_cnt <= wr_cnt + CNT_ONE;
      end
      if (rd_rsp_hs && !icb_rsp_err) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          hop_cnt <= hop_cnt + 16'd1;
        end else begin
          rd_cnt <= rd_cnt + CNT_ONE;
        end
      end
      if (state == ERR && clr_err) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
    end
  end

  // One-entry result register; a reload in the drain cycle wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (rd_rsp_hs && !icb_rsp_err) begin
        m_valid <= 1'b1;
        m_data  <= icb_rsp_rdata;
      end
    end
  end

  // Sticky fault capture and clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err      <= 1'b0;
      err_code <= '0;
    end else if ((wr_rsp_hs || rd_rsp_hs) && icb_rsp_err) begin
      err      <= 1'b1;
      err_code <= icb_rsp_rdata;
    end else if (state == ERR && clr_err) begin
      err      <= 1'b0;
      err_code <= '0;
    end
  end

endmodule
